// File: rtl/lpc_record_serializer.sv
// LPC record serializer: buffers decoded LPC transactions in a small record
// FIFO and emits each one as an 11-byte framed stream over a valid/ready
// byte interface. Frame: 5A, {ct_dir,drop,size}, addr[4], data[4], xor.

package lpc_record_serializer_pkg;

  // One captured decoder transaction (71 bits).
  typedef struct packed {
    logic [3:0]  ct_dir;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  size;
  } lpc_rec_t;

endpackage : lpc_record_serializer_pkg

module lpc_record_serializer
  import lpc_record_serializer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DROP_W     = 16
) (
  input  logic                          lpc_clock,
  input  logic                          lpc_reset,
  input  logic                          in_valid,
  input  logic [3:0]                    in_cyctype_dir,
  input  logic [31:0]                   in_addr,
  input  logic [31:0]                   in_data,
  input  logic [2:0]                    in_data_size,
  output logic [7:0]                    out_byte,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DROP_W-1:0]             drop_count
);

  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W    = PTR_W + 1;
  localparam int unsigned FRAME_W  = 80;
  localparam logic [7:0]  MARKER   = 8'h5A;
  localparam logic [3:0]  LAST_IDX = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t               state_q;
  state_t               state_d;

  lpc_rec_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 drop_flag;

  logic [3:0]           byte_idx;
  logic [3:0]           byte_idx_d;
  logic [FRAME_W-1:0]   frame;
  logic [FRAME_W-1:0]   frame_d;
  logic [7:0]           out_byte_d;
  logic                 out_valid_d;

  logic                 full_c;
  logic                 push_c;
  logic                 drop_c;
  logic                 load_c;
  logic                 handshake_c;
  lpc_rec_t             in_rec_c;
  lpc_rec_t             head_c;
  logic [7:0]           b1_c;
  logic [7:0]           csum_c;
  logic [FRAME_W-1:0]   new_frame_c;

  // Capture qualification against the registered level; a same-cycle pop
  // does not free a slot for the incoming record.
  assign full_c      = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign push_c      = in_valid && !full_c;
  assign drop_c      = in_valid && full_c;
  assign handshake_c = out_valid && out_ready;

  // Pack the incoming decoder fields into a record.
  always_comb begin
    in_rec_c        = '0;
    in_rec_c.ct_dir = in_cyctype_dir;
    in_rec_c.addr   = in_addr;
    in_rec_c.data   = in_data;
    in_rec_c.size   = in_data_size;
  end

  // Build bytes B1..B10 of the frame from the FIFO head.
  always_comb begin
    head_c = mem[rd_ptr];
    b1_c   = {head_c.ct_dir, drop_flag, head_c.size};
    csum_c = b1_c;
    for (int i = 0; i < 4; i++) begin
      csum_c = csum_c ^ head_c.addr[8*i +: 8] ^ head_c.data[8*i +: 8];
    end
    new_frame_c = {b1_c, head_c.addr, head_c.data, csum_c};
  end

  // Record storage; pointer reset alone discards the contents.
  always_ff @(posedge lpc_clock) begin
    if (push_c) begin
      mem[wr_ptr] <= in_rec_c;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge lpc_clock) begin
    if (lpc_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (load_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_c && !load_c) begin
        fifo_level <= fifo_level + LVL_W'(1);
      end else if (!push_c && load_c) begin
        fifo_level <= fifo_level - LVL_W'(1);
      end
    end
  end

  // Saturating drop counter and sticky drop flag; a drop wins over the
  // clear that accompanies a load in the same cycle.
  always_ff @(posedge lpc_clock) begin
    if (lpc_reset) begin
      drop_count <= '0;
      drop_flag  <= 1'b0;
    end else begin
      if (drop_c && (drop_count != {DROP_W{1'b1}})) begin
        drop_count <= drop_count + DROP_W'(1);
      end
      if (drop_c) begin
        drop_flag <= 1'b1;
      end else if (load_c) begin
        drop_flag <= 1'b0;
      end
    end
  end

  // Serializer state register and registered byte outputs.
  always_ff @(posedge lpc_clock) begin
    if (lpc_reset) begin
      state_q   <= ST_IDLE;
      byte_idx  <= '0;
      frame     <= '0;
      out_byte  <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      byte_idx  <= byte_idx_d;
      frame     <= frame_d;
      out_byte  <= out_byte_d;
      out_valid <= out_valid_d;
    end
  end

  // Next-state: load a record from IDLE, then shift bytes out on handshakes.
  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx;
    frame_d     = frame;
    out_byte_d  = out_byte;
    out_valid_d = out_valid;
    load_c      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        out_valid_d = 1'b0;
        if (fifo_level != '0) begin
          load_c      = 1'b1;
          frame_d     = new_frame_c;
          byte_idx_d  = '0;
          out_byte_d  = MARKER;
          out_valid_d = 1'b1;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (handshake_c) begin
          if (byte_idx == LAST_IDX) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            byte_idx_d = byte_idx + 4'd1;
            out_byte_d = frame[FRAME_W-1 -: 8];
            frame_d    = {frame[FRAME_W-9:0], 8'h00};
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule : lpc_record_serializer

// File: tb/tb_lpc_record_serializer.sv
// Bench for lpc_record_serializer: queue-based reference model of the FIFO
// and byte stream, a per-cycle compare process, and directed scenarios with
// hand-computed expectations.

module tb_lpc_record_serializer;

  localparam int unsigned DEPTH = 4;

  logic        lpc_clock = 1'b0;
  logic        lpc_reset;
  logic        in_valid;
  logic [3:0]  in_cyctype_dir;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [2:0]  in_data_size;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fifo_level;
  logic [15:0] drop_count;

  lpc_record_serializer #(.FIFO_DEPTH(DEPTH), .DROP_W(16)) dut (
    .lpc_clock      (lpc_clock),
    .lpc_reset      (lpc_reset),
    .in_valid       (in_valid),
    .in_cyctype_dir (in_cyctype_dir),
    .in_addr        (in_addr),
    .in_data        (in_data),
    .in_data_size   (in_data_size),
    .out_byte       (out_byte),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .fifo_level     (fifo_level),
    .drop_count     (drop_count)
  );

  always #5 lpc_clock = ~lpc_clock;

  typedef struct {
    logic [3:0]  ct;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  size;
  } m_rec_t;

  int          vectors     = 0;
  int          miscompares = 0;
  bit          cmp_en      = 1'b0;

  m_rec_t      mq[$];
  logic [7:0]  cur[$];
  logic [7:0]  cap[$];
  logic        m_flag;
  logic [15:0] m_drops;
  bit          m_full;
  m_rec_t      m_head;
  m_rec_t      m_in;
  logic [7:0]  m_bytes [11];
  logic [7:0]  t1_exp [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: records queue, bytes of the frame in flight, drop state.
  always @(posedge lpc_clock) begin
    if (lpc_reset) begin
      mq.delete();
      cur.delete();
      m_flag  = 1'b0;
      m_drops = 16'd0;
    end else begin
      m_full = (mq.size() == DEPTH);
      if (cur.size() != 0) begin
        if (out_ready) void'(cur.pop_front());
      end else if (mq.size() != 0) begin
        m_head     = mq.pop_front();
        m_bytes[0] = 8'h5A;
        m_bytes[1] = {m_head.ct, m_flag, m_head.size};
        for (int i = 0; i < 4; i++) begin
          m_bytes[2+i] = m_head.addr[31-8*i -: 8];
          m_bytes[6+i] = m_head.data[31-8*i -: 8];
        end
        m_bytes[10] = 8'h00;
        for (int i = 1; i < 10; i++) m_bytes[10] = m_bytes[10] ^ m_bytes[i];
        for (int i = 0; i < 11; i++) cur.push_back(m_bytes[i]);
        m_flag = 1'b0;
      end
      if (in_valid) begin
        if (m_full) begin
          if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
          m_flag = 1'b1;
        end else begin
          m_in.ct   = in_cyctype_dir;
          m_in.addr = in_addr;
          m_in.data = in_data;
          m_in.size = in_data_size;
          mq.push_back(m_in);
        end
      end
    end
  end

  // Record every accepted byte for the hand-checked scenarios.
  always @(posedge lpc_clock) begin
    if (!lpc_reset && out_valid === 1'b1 && out_ready === 1'b1) cap.push_back(out_byte);
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge lpc_clock) begin
    if (cmp_en) begin
      chk("out_valid", 32'(out_valid), 32'(cur.size() != 0));
      if (cur.size() != 0) chk("out_byte", 32'(out_byte), 32'(cur[0]));
      chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
      chk("drop_count", 32'(drop_count), 32'(m_drops));
    end
  end

  task automatic strobe(input logic [3:0] ct, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] s);
    in_cyctype_dir = ct;
    in_addr        = a;
    in_data        = d;
    in_data_size   = s;
    in_valid       = 1'b1;
    @(posedge lpc_clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((out_valid !== 1'b0 || fifo_level != 3'd0 || cur.size() != 0) && n < budget) begin
      @(posedge lpc_clock);
      #1;
      n++;
    end
    chk(name, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int n;
    int peak;
    t1_exp = '{8'h5A, 8'h42, 8'hAF, 8'hFE, 8'h7F, 8'hE5, 8'h00, 8'h00, 8'hDF, 8'h6C, 8'h3A};
    lpc_reset = 1'b1;
    in_valid = 1'b0; in_cyctype_dir = '0; in_addr = '0; in_data = '0; in_data_size = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge lpc_clock);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_byte", 32'(out_byte), 32'd0);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    lpc_reset = 1'b0;
    cmp_en = 1'b1;
    @(posedge lpc_clock);
    #1;

    // T1: single record, latency and literal frame
    cap.delete();
    strobe(4'h4, 32'haffe7fe5, 32'h0000df6c, 3'd2);
    chk("t1_valid_after_N", 32'(out_valid), 32'd0);
    chk("t1_level_after_N", 32'(fifo_level), 32'd1);
    @(posedge lpc_clock);
    #1;
    chk("t1_valid_after_N1", 32'(out_valid), 32'd1);
    chk("t1_first_byte", 32'(out_byte), 32'h5A);
    wait_idle("t1_done", 100);
    chk("t1_count", 32'(cap.size()), 32'd11);
    for (int i = 0; i < 11 && i < cap.size(); i++) chk($sformatf("t1_byte%0d", i), 32'(cap[i]), 32'(t1_exp[i]));

    // T2: same record under random backpressure
    cap.delete();
    strobe(4'h4, 32'haffe7fe5, 32'h0000df6c, 3'd2);
    n = 0;
    while ((out_valid || fifo_level != 3'd0 || cur.size() != 0) && n < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge lpc_clock);
      #1;
      n++;
    end
    out_ready = 1'b1;
    chk("t2_done", 32'(n < 300), 32'd1);
    chk("t2_count", 32'(cap.size()), 32'd11);
    for (int i = 0; i < 11 && i < cap.size(); i++) chk($sformatf("t2_byte%0d", i), 32'(cap[i]), 32'(t1_exp[i]));

    // T3: 4 back-to-back records; one enters the serializer so the peak is 3
    cap.delete();
    peak = 0;
    for (int i = 0; i < 4; i++) begin
      strobe(4'(i + 1), 32'h1000_0000 + 32'(i * 17), 32'hC0DE_0000 + 32'(i), 3'(i));
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
    chk("t3_peak", 32'(peak), 32'd3);
    wait_idle("t3_done", 300);
    chk("t3_count", 32'(cap.size()), 32'd44);
    chk("t3_drops", 32'(drop_count), 32'd0);

    // T4: 7 strobes with the sink stalled: 1 in serializer, 4 queued, 2 dropped
    cap.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) strobe(4'h2, 32'h0000_0080 + 32'(i), 32'(i * 3), 3'd0);
    chk("t4_level", 32'(fifo_level), 32'd4);
    chk("t4_drops", 32'(drop_count), 32'd2);
    out_ready = 1'b1;
    wait_idle("t4_done", 300);
    chk("t4_count", 32'(cap.size()), 32'd55);
    for (int r = 0; r < 5 && (r * 11 + 1) < cap.size(); r++)
      chk($sformatf("t4_dropbit_rec%0d", r), 32'(cap[r*11+1][3]), 32'(r == 1));

    // T5: reset mid-record with a second record queued and drops outstanding
    cap.delete();
    strobe(4'h3, 32'h1234_5678, 32'h9abc_def0, 3'd4);
    strobe(4'h5, 32'h0bad_f00d, 32'h0000_0011, 3'd1);
    n = 0;
    while (cap.size() < 5 && n < 50) begin
      @(posedge lpc_clock);
      #1;
      n++;
    end
    chk("t5_reached_b5", 32'(cap.size()), 32'd5);
    lpc_reset = 1'b1;
    @(posedge lpc_clock);
    #1;
    lpc_reset = 1'b0;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_level", 32'(fifo_level), 32'd0);
    chk("t5_drops", 32'(drop_count), 32'd0);
    cap.delete();
    strobe(4'h4, 32'haffe7fe5, 32'h0000df6c, 3'd2);
    wait_idle("t5_done", 100);
    chk("t5_count", 32'(cap.size()), 32'd11);
    for (int i = 0; i < 11 && i < cap.size(); i++) chk($sformatf("t5_byte%0d", i), 32'(cap[i]), 32'(t1_exp[i]));

    // T6: full FIFO, IDLE load coincides with a new strobe
    cap.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) strobe(4'h6, 32'h0000_0400 + 32'(i), 32'hFFFF_0000 + 32'(i), 3'd3);
    chk("t6_level_full", 32'(fifo_level), 32'd4);
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 50) begin
      @(posedge lpc_clock);
      #1;
      n++;
    end
    chk("t6_idle_reached", 32'(out_valid), 32'd0);
    chk("t6_level_idle", 32'(fifo_level), 32'd4);
    strobe(4'h7, 32'hDEAD_BEEF, 32'h0000_0001, 3'd1);
    chk("t6_drops", 32'(drop_count), 32'd1);
    chk("t6_level", 32'(fifo_level), 32'd3);
    chk("t6_sending", 32'(out_valid), 32'd1);
    wait_idle("t6_done", 300);
    chk("t6_count", 32'(cap.size()), 32'd55);

    repeat (2) @(posedge lpc_clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_lpc_record_serializer
